// File: rtl/shift_unit_if.sv
// shift_unit_if: start/done handshake, operand and flag bundle for shift_unit_seq
interface shift_unit_if #(
  parameter int WIDTH = 8,
  parameter int SHAMT_W = $clog2(WIDTH + 1)
) ();
  logic start;
  logic [1:0] op;
  logic [WIDTH-1:0] a;
  logic [SHAMT_W-1:0] amount;
  logic busy;
  logic done;
  logic [WIDTH-1:0] result;
  logic zero_flag;
  logic carry_flag;
  modport master (output start, op, a, amount, input busy, done, result, zero_flag, carry_flag);
  modport slave (input start, op, a, amount, output busy, done, result, zero_flag, carry_flag);
endinterface

// File: rtl/shift_unit_seq.sv
// shift_unit_seq: multi-cycle LSR/LSL/ASR/ROR shifter, one bit position per clock
module shift_unit_seq #(
  parameter int WIDTH = 8,
  parameter int SHAMT_W = $clog2(WIDTH + 1)
) (
  input logic clk,
  input logic rst,
  shift_unit_if.slave bus
);
  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;
  state_t state;
  logic [WIDTH-1:0] work, step_work, result;
  logic [SHAMT_W-1:0] count;
  logic [1:0] op_q;
  logic carry, step_carry, busy, done, zero_flag, carry_flag;
  always_comb begin
    step_work = op_q == 2'b01 ? {work[WIDTH-2:0], 1'b0}
              : {op_q == 2'b10 ? work[WIDTH-1] : op_q == 2'b11 ? work[0] : 1'b0, work[WIDTH-1:1]};
    step_carry = op_q == 2'b01 ? work[WIDTH-1] : work[0];
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      busy <= 1'b0;
      done <= 1'b0;
      result <= '0;
      zero_flag <= 1'b0;
      carry_flag <= 1'b0;
      work <= '0;
      count <= '0;
      op_q <= 2'b00;
      carry <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (bus.start) begin
            work <= bus.a;
            count <= bus.amount;
            op_q <= bus.op;
            carry <= 1'b0;
            if (bus.amount != '0) begin
              state <= SHIFT;
              busy <= 1'b1;
            end else begin
              // zero-length shift publishes the operand unchanged on the accepting edge
              state <= DONE;
              done <= 1'b1;
              result <= bus.a;
              zero_flag <= bus.a == '0;
              carry_flag <= 1'b0;
            end
          end
        end
        SHIFT: begin
          work <= step_work;
          carry <= step_carry;
          count <= count - SHAMT_W'(1);
          if (count == SHAMT_W'(1)) begin
            state <= DONE;
            busy <= 1'b0;
            done <= 1'b1;
            result <= step_work;
            zero_flag <= step_work == '0;
            carry_flag <= step_carry;
          end
        end
        default: begin
          done <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end
  assign bus.busy = busy;
  assign bus.done = done;
  assign bus.result = result;
  assign bus.zero_flag = zero_flag;
  assign bus.carry_flag = carry_flag;
endmodule

// File: tb/tb_shift_unit_seq.sv
// tb_shift_unit_seq: directed scoreboard bench for 8-bit and 4-bit shift_unit_seq
module tb_shift_unit_seq;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int checks = 0;
  int errors = 0;
  logic [9:0] sb[$];
  always #5 clk = ~clk;
  shift_unit_if #(.WIDTH(8)) bus8 ();
  shift_unit_if #(.WIDTH(4)) bus4 ();
  shift_unit_seq #(.WIDTH(8)) dut8 (.clk(clk), .rst(rst), .bus(bus8.slave));
  shift_unit_seq #(.WIDTH(4)) dut4 (.clk(clk), .rst(rst), .bus(bus4.slave));
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  function automatic logic [9:0] model8(input logic [1:0] o, input logic [7:0] x, input int n);
    logic [7:0] w = x;
    logic c = 1'b0;
    for (int i = 0; i < n; i++) begin
      case (o)
        2'b00: begin c = w[0]; w = w >> 1; end
        2'b01: begin c = w[7]; w = w << 1; end
        2'b10: begin c = w[0]; w = {w[7], w[7:1]}; end
        default: begin c = w[0]; w = {w[0], w[7:1]}; end
      endcase
    end
    return {c, w == 8'h00, w};
  endfunction
  task automatic go8(input string tag, input logic [1:0] o, input logic [7:0] x, input int n, input bit poke);
    int cyc = 0;
    int busy_cnt = 0;
    logic [9:0] e;
    sb.push_back(model8(o, x, n));
    @(negedge clk);
    bus8.start = 1'b1; bus8.op = o; bus8.a = x; bus8.amount = 4'(n);
    @(negedge clk);
    bus8.start = 1'b0; bus8.op = ~o; bus8.a = ~x; bus8.amount = 4'd5;
    while (!bus8.done && cyc < 100) begin
      if (bus8.busy) busy_cnt++;
      if (poke && cyc == 4) begin bus8.start = 1'b1; bus8.a = 8'h55; end else bus8.start = 1'b0;
      @(negedge clk);
      cyc++;
    end
    bus8.start = 1'b0;
    chk({tag, "_latency"}, cyc, n);
    chk({tag, "_busy_cycles"}, busy_cnt, n);
    e = sb.pop_front();
    chk({tag, "_result"}, bus8.result, e[7:0]);
    chk({tag, "_zero"}, bus8.zero_flag, e[8]);
    chk({tag, "_carry"}, bus8.carry_flag, e[9]);
    @(negedge clk);
    chk({tag, "_done_pulse"}, bus8.done, 0);
    chk({tag, "_result_hold"}, bus8.result, e[7:0]);
  endtask
  initial begin
    bus8.start = 1'b0; bus8.op = 2'b00; bus8.a = '0; bus8.amount = '0;
    bus4.start = 1'b0; bus4.op = 2'b00; bus4.a = '0; bus4.amount = '0;
    #12;
    chk("rst_outputs8", {bus8.busy, bus8.done, bus8.zero_flag, bus8.carry_flag, bus8.result}, 0);
    chk("rst_outputs4", {bus4.busy, bus4.done, bus4.zero_flag, bus4.carry_flag, bus4.result}, 0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    bus4.start = 1'b1; bus4.op = 2'b00; bus4.a = 4'b1011; bus4.amount = 3'd1;
    @(negedge clk);
    bus4.start = 1'b0;
    chk("w4_busy_after_accept", {bus4.busy, bus4.done}, 2'b10);
    @(negedge clk);
    chk("w4_done", {bus4.busy, bus4.done}, 2'b01);
    chk("w4_result", bus4.result, 4'b0101);
    chk("w4_flags", {bus4.carry_flag, bus4.zero_flag}, 2'b10);
    go8("asr96", 2'b10, 8'h96, 3, 1'b0);
    chk("asr96_expected_const", bus8.result, 8'hF2);
    go8("lsl81", 2'b01, 8'h81, 1, 1'b0);
    go8("ror01", 2'b11, 8'h01, 8, 1'b0);
    chk("ror01_expected_const", {bus8.carry_flag, bus8.result}, 9'h001);
    go8("amt0", 2'b00, 8'h00, 0, 1'b0);
    go8("lsr_ff_12", 2'b00, 8'hFF, 12, 1'b1);
    chk("lsr_ff_12_const", {bus8.carry_flag, bus8.zero_flag, bus8.result}, 10'h100);
    go8("asr_over", 2'b10, 8'h80, 11, 1'b0);
    go8("ror_over", 2'b11, 8'hA3, 11, 1'b0);
    go8("lsl_b4", 2'b01, 8'hB4, 5, 1'b0);
    @(negedge clk);
    bus8.start = 1'b1; bus8.op = 2'b00; bus8.a = 8'hF0; bus8.amount = 4'd6;
    @(negedge clk);
    bus8.start = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    #1;
    chk("abort_outputs", {bus8.busy, bus8.done, bus8.zero_flag, bus8.carry_flag, bus8.result}, 0);
    @(negedge clk);
    rst = 1'b0;
    go8("after_rst", 2'b00, 8'hB4, 2, 1'b0);
    chk("after_rst_const", bus8.result, 8'h2D);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
